// File: rtl/ldb_burst_mc.sv
// Multi-channel load-burst engine: splits an LDB packet into AXI read sub-requests
// and scatters each returned 16B beat into the UR of every selected SMC.
module ldb_burst_mc #(
    parameter int SMC_CNT     = 1,
    parameter int UR_ADDR_W   = 11,
    parameter int GR_ADDR_W   = 64,
    parameter int BRST_W      = 16,
    parameter int MAX_SUB_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [127:0]         cru_ldb_i,
    input  logic [1:0]           crd_ldb_i,
    output logic                 axi_req_valid,
    input  logic                 axi_req_ready,
    output logic [GR_ADDR_W-1:0] axi_req_addr,
    output logic [8:0]           axi_req_len,
    input  logic                 axi_req_done,
    input  logic                 axi_req_err,
    input  logic                 axi_data_valid,
    input  logic [127:0]         axi_data,
    input  logic                 axi_data_last,
    output logic [SMC_CNT-1:0]   ur_we,
    output logic [UR_ADDR_W-1:0] ur_addr,
    output logic [127:0]         ur_wdata,
    output logic [15:0]          ur_wstrb,
    output logic [7:0]           ur_id,
    output logic                 busy,
    output logic [127:0]         cru_ldb_o,
    output logic [1:0]           crd_ldb_o
);

    typedef enum logic [2:0] {IDLE, REQ, DATA, RESP, DONE} state_t;

    state_t                state;
    logic [5:0]            smc_strb_q;
    logic [3:0]            byte_strb_q;
    logic [BRST_W-1:0]     remaining;
    logic [BRST_W-1:0]     beats_issued;
    logic [BRST_W-1:0]     sub_left;
    logic [GR_ADDR_W-1:0]  gr_base;
    logic [UR_ADDR_W-1:0]  ur_ptr;
    logic                  err;

    logic [BRST_W-1:0]     pkt_burst;
    logic [GR_ADDR_W-1:0]  pkt_gr;
    logic [GR_ADDR_W-1:0]  nxt_gr;
    logic                  last_beat;
    logic [15:0]           beat_strb;
    logic [127:0]          beat_data;
    logic                  unused_bits;

    assign cru_ldb_o   = cru_ldb_i;
    assign busy        = (state != IDLE);
    assign pkt_burst   = BRST_W'(cru_ldb_i[116:101]);
    assign pkt_gr      = GR_ADDR_W'(cru_ldb_i[100:37]);
    assign nxt_gr      = gr_base + GR_ADDR_W'(beats_issued);
    assign unused_bits = ^{crd_ldb_i, cru_ldb_i[17:0]};

    function automatic logic [8:0] sub_len(input logic [BRST_W-1:0] rem);
        return (rem > BRST_W'(MAX_SUB_LEN)) ? 9'(MAX_SUB_LEN) : 9'(rem);
    endfunction

    // Only the very last beat of the whole burst can carry a partial strobe.
    assign last_beat = (remaining == '0) && (sub_left == BRST_W'(1));

    always_comb begin
        beat_strb = 16'hFFFF;
        beat_data = '0;
        if (last_beat && byte_strb_q != 4'd0)
            beat_strb = (16'd1 << byte_strb_q) - 16'd1;
        for (int b = 0; b < 16; b++)
            beat_data[b*8 +: 8] = beat_strb[b] ? axi_data[b*8 +: 8] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            smc_strb_q    <= '0;
            byte_strb_q   <= '0;
            remaining     <= '0;
            beats_issued  <= '0;
            sub_left      <= '0;
            gr_base       <= '0;
            ur_ptr        <= '0;
            err           <= 1'b0;
            axi_req_valid <= 1'b0;
            axi_req_addr  <= '0;
            axi_req_len   <= '0;
            ur_we         <= '0;
            ur_addr       <= '0;
            ur_wdata      <= '0;
            ur_wstrb      <= '0;
            ur_id         <= '0;
            crd_ldb_o     <= '0;
        end else begin
            ur_we     <= '0;
            crd_ldb_o <= '0;
            case (state)
                IDLE: if (cru_ldb_i[127]) begin
                    smc_strb_q   <= cru_ldb_i[126:121];
                    byte_strb_q  <= cru_ldb_i[120:117];
                    gr_base      <= pkt_gr;
                    ur_id        <= cru_ldb_i[36:29];
                    ur_ptr       <= UR_ADDR_W'(cru_ldb_i[28:18]);
                    remaining    <= pkt_burst;
                    beats_issued <= '0;
                    err          <= 1'b0;
                    if (pkt_burst == '0) begin
                        state <= DONE;
                    end else begin
                        state         <= REQ;
                        axi_req_valid <= 1'b1;
                        axi_req_addr  <= pkt_gr << 4;
                        axi_req_len   <= sub_len(pkt_burst);
                    end
                end
                REQ: if (axi_req_ready) begin
                    axi_req_valid <= 1'b0;
                    sub_left      <= BRST_W'(axi_req_len);
                    remaining     <= remaining - BRST_W'(axi_req_len);
                    beats_issued  <= beats_issued + BRST_W'(axi_req_len);
                    state         <= DATA;
                end
                DATA: if (axi_data_valid) begin
                    ur_we    <= SMC_CNT'(smc_strb_q);
                    ur_addr  <= ur_ptr;
                    ur_wdata <= beat_data;
                    ur_wstrb <= beat_strb;
                    ur_ptr   <= ur_ptr + UR_ADDR_W'(1);
                    sub_left <= sub_left - BRST_W'(1);
                    // last must coincide exactly with the len-th beat
                    if (axi_data_last != (sub_left == BRST_W'(1)))
                        err <= 1'b1;
                    if (sub_left == BRST_W'(1))
                        state <= RESP;
                end
                RESP: if (axi_req_done) begin
                    if (remaining != '0) begin
                        state         <= REQ;
                        axi_req_valid <= 1'b1;
                        axi_req_addr  <= nxt_gr << 4;
                        axi_req_len   <= sub_len(remaining);
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    crd_ldb_o <= {1'b1, ~err};
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A bus error overrides whatever the state did this cycle.
            if (axi_req_err && (state == REQ || state == DATA || state == RESP)) begin
                err           <= 1'b1;
                state         <= DONE;
                axi_req_valid <= 1'b0;
                ur_we         <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ldb_burst_mc.sv
// Randomized scoreboard bench for ldb_burst_mc: a packet-level model queues the
// expected AXI requests, UR writes and completions; a negedge monitor checks them.
module tb_ldb_burst_mc;
    localparam int SMC = 4;

    typedef struct {
        logic [63:0] addr;
        logic [8:0]  len;
    } req_t;

    typedef struct {
        logic [SMC-1:0] we;
        logic [10:0]    addr;
        logic [127:0]   data;
        logic [15:0]    strb;
        logic [7:0]     id;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [127:0]   cru_ldb_i;
    logic [1:0]     crd_ldb_i;
    logic           axi_req_valid;
    logic           axi_req_ready;
    logic [63:0]    axi_req_addr;
    logic [8:0]     axi_req_len;
    logic           axi_req_done;
    logic           axi_req_err;
    logic           axi_data_valid;
    logic [127:0]   axi_data;
    logic           axi_data_last;
    logic [SMC-1:0] ur_we;
    logic [10:0]    ur_addr;
    logic [127:0]   ur_wdata;
    logic [15:0]    ur_wstrb;
    logic [7:0]     ur_id;
    logic           busy;
    logic [127:0]   cru_ldb_o;
    logic [1:0]     crd_ldb_o;

    ldb_burst_mc #(.SMC_CNT(SMC), .UR_ADDR_W(11), .GR_ADDR_W(64), .BRST_W(16), .MAX_SUB_LEN(16)) dut (
        .clk(clk), .rst(rst), .cru_ldb_i(cru_ldb_i), .crd_ldb_i(crd_ldb_i),
        .axi_req_valid(axi_req_valid), .axi_req_ready(axi_req_ready),
        .axi_req_addr(axi_req_addr), .axi_req_len(axi_req_len),
        .axi_req_done(axi_req_done), .axi_req_err(axi_req_err),
        .axi_data_valid(axi_data_valid), .axi_data(axi_data), .axi_data_last(axi_data_last),
        .ur_we(ur_we), .ur_addr(ur_addr), .ur_wdata(ur_wdata), .ur_wstrb(ur_wstrb),
        .ur_id(ur_id), .busy(busy), .cru_ldb_o(cru_ldb_o), .crd_ldb_o(crd_ldb_o)
    );

    req_t       exp_req[$];
    wr_t        exp_wr[$];
    logic [1:0] exp_crd[$];
    int         vectors = 0;
    int         miscompares = 0;

    function automatic logic [127:0] dfun(input logic [63:0] a);
        return {a ^ 64'h0123_4567_89AB_CDEF, ~a ^ {a[31:0], a[63:32]}};
    endfunction

    function automatic logic [127:0] mkpkt(input logic [5:0] smc, input logic [3:0] bs, input int burst,
                                           input logic [63:0] gr, input logic [7:0] id, input logic [10:0] ua);
        return {1'b1, smc, bs, 16'(burst), gr, id, ua, 18'd0};
    endfunction

    function automatic bit outs_nonzero();
        return axi_req_valid || (axi_req_addr != 0) || (axi_req_len != 0) || (ur_we != 0) ||
               (ur_addr != 0) || (ur_wdata != 0) || (ur_wstrb != 0) || (ur_id != 0) ||
               busy || (crd_ldb_o != 0);
    endfunction

    // Packet-level reference: what the bus and the URs should see for one packet.
    task automatic model(input logic [5:0] smc, input logic [3:0] bs, input int burst,
                         input logic [63:0] gr, input logic [7:0] id, input logic [10:0] ua, input int err_at);
        int   i, len, nb;
        req_t r;
        wr_t  w;
        i = 0;
        while (i < burst) begin
            if (err_at >= 0 && i > err_at) break;
            len = (burst - i > 16) ? 16 : burst - i;
            r.addr = (gr + 64'(i)) * 64'd16;
            r.len  = 9'(len);
            exp_req.push_back(r);
            i += len;
        end
        nb = (err_at >= 0) ? err_at : burst;
        for (int j = 0; j < nb; j++) begin
            if (smc[SMC-1:0] == 0) break;
            w.we   = smc[SMC-1:0];
            w.addr = 11'(int'(ua) + j);
            w.id   = id;
            w.strb = 16'hFFFF;
            if (j == burst - 1 && bs != 0)
                for (int k = 0; k < 16; k++) w.strb[k] = (k < int'(bs));
            w.data = dfun((gr + 64'(j)) * 64'd16);
            for (int k = 0; k < 16; k++)
                if (!w.strb[k]) w.data[k*8 +: 8] = 8'h00;
            exp_wr.push_back(w);
        end
        exp_crd.push_back((err_at >= 0) ? 2'b10 : 2'b11);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        exp_req.delete(); exp_wr.delete(); exp_crd.delete();
        vectors++;
        if (outs_nonzero()) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b we=%b busy=%b crd=%b, required all zero", axi_req_valid, ur_we, busy, crd_ldb_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        vectors++;
        if (busy) begin miscompares++; $display("FAIL reset_idle: busy=%b, required 0", busy); end
    endtask

    // Drives one packet and acts as the AXI read slave until the engine goes idle.
    task automatic run_pkt(input logic [5:0] smc, input logic [3:0] bs, input int burst,
                           input logic [63:0] gr, input logic [7:0] id, input logic [10:0] ua,
                           input int err_at, input int rst_at, input int rdy_dly);
        logic [63:0] base;
        int          len, gbeat, n, nreq;
        bit          stop;
        model(smc, bs, burst, gr, id, ua, err_at);
        @(posedge clk); #1;
        cru_ldb_i = mkpkt(smc, bs, burst, gr, id, ua);
        @(posedge clk); #1;
        cru_ldb_i = '0;
        if (burst == 0) begin
            @(posedge clk); #1;
            vectors++;
            if (crd_ldb_o !== 2'b11 || axi_req_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_burst_crd: crd=%b valid=%b, required crd=11 valid=0", crd_ldb_o, axi_req_valid);
            end
        end
        gbeat = 0; stop = 0; nreq = 0;
        while (busy && !stop && nreq < 300) begin
            n = 0;
            while (busy && !axi_req_valid && n < 100) begin @(posedge clk); #1; n++; end
            if (!busy) break;
            if (n >= 100) begin
                vectors++; miscompares++;
                $display("FAIL req_timeout: no axi_req_valid within 100 cycles");
                break;
            end
            nreq++;
            repeat ((rdy_dly >= 0) ? rdy_dly : $urandom_range(0, 3)) begin @(posedge clk); #1; end
            axi_req_ready = 1'b1;
            base = axi_req_addr;
            len  = int'(axi_req_len);
            @(posedge clk); #1;
            axi_req_ready = 1'b0;
            for (int b = 0; b < len && !stop; b++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if (gbeat == rst_at) begin
                    do_reset();
                    stop = 1;
                end else if (gbeat == err_at) begin
                    axi_req_err = 1'b1;
                    @(posedge clk); #1;
                    axi_req_err = 1'b0;
                    stop = 1;
                end else begin
                    axi_data_valid = 1'b1;
                    axi_data       = dfun(base + 64'(16 * b));
                    axi_data_last  = (b == len - 1);
                    @(posedge clk); #1;
                    axi_data_valid = 1'b0;
                    axi_data_last  = 1'b0;
                    gbeat++;
                end
            end
            if (!stop) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                axi_req_done = 1'b1;
                @(posedge clk); #1;
                axi_req_done = 1'b0;
            end
        end
        n = 0;
        while (busy && n < 50) begin @(posedge clk); #1; n++; end
        if (busy) begin
            vectors++; miscompares++;
            $display("FAIL idle_timeout: busy still %b after packet", busy);
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents something.
    logic        prev_pend = 1'b0;
    logic [63:0] prev_addr;
    logic [8:0]  prev_len;
    req_t        m_r;
    wr_t         m_w;
    logic [1:0]  m_c;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                vectors++;
                if (!axi_req_valid || axi_req_addr != prev_addr || axi_req_len != prev_len) begin
                    miscompares++;
                    $display("FAIL req_hold: valid=%b addr=%h len=%0d, required 1 %h %0d", axi_req_valid, axi_req_addr, axi_req_len, prev_addr, prev_len);
                end
            end
            prev_pend = axi_req_valid && !axi_req_ready;
            prev_addr = axi_req_addr;
            prev_len  = axi_req_len;
            if (axi_req_valid && axi_req_ready) begin
                vectors++;
                if (exp_req.size() == 0) begin
                    miscompares++;
                    $display("FAIL axi_req unexpected: addr=%h len=%0d", axi_req_addr, axi_req_len);
                end else begin
                    m_r = exp_req.pop_front();
                    if (axi_req_addr !== m_r.addr || axi_req_len !== m_r.len) begin
                        miscompares++;
                        $display("FAIL axi_req: addr=%h len=%0d, required addr=%h len=%0d", axi_req_addr, axi_req_len, m_r.addr, m_r.len);
                    end
                end
            end
            if (ur_we != '0) begin
                vectors++;
                if (exp_wr.size() == 0) begin
                    miscompares++;
                    $display("FAIL ur_write unexpected: we=%b addr=%h", ur_we, ur_addr);
                end else begin
                    m_w = exp_wr.pop_front();
                    if (ur_we !== m_w.we || ur_addr !== m_w.addr || ur_wdata !== m_w.data ||
                        ur_wstrb !== m_w.strb || ur_id !== m_w.id) begin
                        miscompares++;
                        $display("FAIL ur_write: we=%b addr=%h strb=%h id=%h data=%h, required we=%b addr=%h strb=%h id=%h data=%h",
                                 ur_we, ur_addr, ur_wstrb, ur_id, ur_wdata, m_w.we, m_w.addr, m_w.strb, m_w.id, m_w.data);
                    end
                end
            end
            if (crd_ldb_o != 2'b00) begin
                vectors++;
                if (exp_crd.size() == 0) begin
                    miscompares++;
                    $display("FAIL crd unexpected: crd=%b", crd_ldb_o);
                end else begin
                    m_c = exp_crd.pop_front();
                    if (crd_ldb_o !== m_c) begin
                        miscompares++;
                        $display("FAIL crd: crd=%b, required %b", crd_ldb_o, m_c);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] r_smc;
        int         r_burst, r_err;
        rst = 1'b1; cru_ldb_i = '0; crd_ldb_i = '0;
        axi_req_ready = 0; axi_req_done = 0; axi_req_err = 0;
        axi_data_valid = 0; axi_data = '0; axi_data_last = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (outs_nonzero()) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b we=%b busy=%b crd=%b, required all zero", axi_req_valid, ur_we, busy, crd_ldb_o);
        end
        cru_ldb_i = {1'b0, $urandom, $urandom, $urandom, 31'($urandom)};
        #1;
        vectors++;
        if (cru_ldb_o !== cru_ldb_i) begin
            miscompares++;
            $display("FAIL passthrough: cru_ldb_o=%h, required %h", cru_ldb_o, cru_ldb_i);
        end
        @(posedge clk); #1;
        cru_ldb_i = '0;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        run_pkt(6'd1, 4'd0, 3, 64'h100, 8'h11, 11'd5, -1, -1, -1);
        run_pkt(6'd1, 4'd0, 40, 64'h100, 8'h12, 11'd0, -1, -1, -1);
        run_pkt(6'd1, 4'd5, 2, 64'h200, 8'h13, 11'd9, -1, -1, -1);
        run_pkt(6'd1, 4'd0, 0, 64'h300, 8'h14, 11'd0, -1, -1, -1);
        run_pkt(6'd3, 4'd7, 20, 64'h400, 8'h15, 11'd20, 5, -1, 4);
        run_pkt(6'b000101, 4'd0, 10, 64'h500, 8'h16, 11'd40, -1, 4, -1);
        run_pkt(6'b000101, 4'd15, 16, 64'h0FFF_FFFF_FFFF_FFFF, 8'h17, 11'h7FE, -1, -1, -1);
        run_pkt(6'b110000, 4'd1, 17, 64'h600, 8'h18, 11'd3, -1, -1, -1);
        run_pkt(6'b111111, 4'd3, 33, 64'h700, 8'h19, 11'h7F0, 16, -1, 0);

        // Packet held valid across DONE: taken again only once IDLE is back.
        exp_crd.push_back(2'b11);
        exp_crd.push_back(2'b11);
        @(posedge clk); #1;
        cru_ldb_i = mkpkt(6'd1, 4'd0, 0, 64'h0, 8'h33, 11'd0);
        repeat (3) begin @(posedge clk); #1; end
        cru_ldb_i = '0;
        repeat (5) begin @(posedge clk); #1; end

        for (int t = 0; t < 14; t++) begin
            r_smc   = 6'($urandom);
            r_burst = $urandom_range(1, 45);
            r_err   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r_burst - 1) : -1;
            run_pkt(r_smc, 4'($urandom), r_burst, {$urandom, $urandom}, 8'($urandom),
                    11'($urandom), r_err, -1, -1);
        end

        repeat (5) begin @(posedge clk); #1; end
        vectors++;
        if (exp_req.size() + exp_wr.size() + exp_crd.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: req=%0d wr=%0d crd=%0d outstanding, required 0", exp_req.size(), exp_wr.size(), exp_crd.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
